shift_pipe: RTL and testbench
=============================

// Module: shift_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter/rotator for the datapath.
//  Implements all four shift ops (ROL, SLL, ROR, SRL) on a WIDTH-bit operand.
//  Uses one pipeline stage per shift-amount bit; stage k shifts by 2^k.
//  Valid/ready handshake on both sides; sits between decode/execute operand muxes and writeback.
// PARAMETERS
//  WIDTH    16                  operand width; power of 2, >= 4
//  CNT_W    $clog2(WIDTH)       shift-amount width = number of pipeline stages (latency)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous reset, active-low
//  flush      in   1        synchronous pipeline clear, active-high
//  in_valid   in   1        request valid
//  in_ready   out  1        block accepts request this cycle
//  in_data    in   WIDTH    operand
//  in_amt     in   CNT_W    shift amount, 0..WIDTH-1
//  in_op      in   2        00 ROL, 01 SLL, 10 ROR, 11 SRL
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_data   out  WIDTH    result
//  busy       out  1        any stage holds a valid entry
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits = 0; data/amt/op regs = 0.
//    out_valid=0, out_data=0, busy=0, in_ready=1 from reset release.
//  - Stage regs S[0..CNT_W-1]: {v, data, amt, op}.
//    Stage k input comes from stage k-1; stage 0 input is the in_* ports.
//  - Stage k: if amt[k]=1, apply the op by 2^k; else pass through.
//    ROL/ROR wrap the vacated bits; SLL/SRL zero-fill.
//  - Stage k registers its input and forwards amt/op unchanged.
//  - Global advance: adv = ~out_valid | out_ready. in_ready = adv.
//    All stages load on adv; all stages hold on ~adv (no bubble collapsing).
//  - Accept: in_valid & in_ready. Stage 0 v <= in_valid & adv.
//    A bubble enters when in_valid=0.
//  - out_valid = S[CNT_W-1].v; out_data = S[CNT_W-1].data.
//    out_data holds stable while out_valid & ~out_ready.
//  - Latency: exactly CNT_W cycles, accept edge to out_valid, when unstalled.
//    Throughput 1 op/cycle.
//  - Simultaneous accept and output pop in one cycle is legal; no loss, no dup.
//  - amt=0: result = in_data for all ops.
//  - flush=1: all v <= 0 at the next edge; in_valid in that cycle is dropped.
//    flush overrides the stall. in_ready stays = adv (drop is silent).
//  - Reset mid-operation: all in-flight entries discarded; no output produced.
//  - busy = OR of all stage v bits.
//  - Results are in issue order. in_op values are all legal; none are reserved.
// TESTING
//  1. Reset: rst_n=0 mid-stream with 3 ops in flight
//     -> out_valid=0 at once; busy=0; nothing emerges after release.
//  2. Ops on WIDTH=16, data 16'h8421, amt=4, out_ready=1:
//     ROL->16'h4218, SLL->16'h4210, ROR->16'h1842, SRL->16'h0842,
//     each 4 cycles after accept.
//  3. Back-to-back: 16 ops, amt 0..15, SRL on 16'hFFFF, out_ready=1
//     -> results 16'hFFFF>>n in order, one per cycle, first at cycle 4.
//  4. Backpressure: out_ready=0 for 5 cycles with pipeline full
//     -> in_ready=0, out_data stable, nothing lost.
//     out_ready=1 -> 4 results drain in order.
//  5. Flush with 2 ops in flight and in_valid=1 -> neither in-flight op nor
//     the flush-cycle op appears. The next op after flush appears after 4 cycles.
//  6. Params WIDTH=32 (CNT_W=5): ROR 32'h00000001 by 31 -> 32'h00000002
//     after 5 cycles. ROL amt=0 -> unchanged.

Source files
------------

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter/rotator (ROL, SLL, ROR, SRL).
// One register stage per shift-amount bit; stage k shifts by 2^k when amt[k] is set.
// All stages advance together on a global advance signal, so latency is exactly CNT_W
// cycles when unstalled and every stage holds while the output is stalled.
module shift_pipe #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CNT_W-1:0] in_amt,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      OP_ROL = 2'b00,
      OP_SLL = 2'b01,
      OP_ROR = 2'b10,
      OP_SRL = 2'b11
   } op_e;

   // Per-stage registers and their next-state values
   logic             v_q    [CNT_W];
   logic             v_d    [CNT_W];
   logic [WIDTH-1:0] data_q [CNT_W];
   logic [WIDTH-1:0] data_d [CNT_W];
   logic [CNT_W-1:0] amt_q  [CNT_W];
   logic [CNT_W-1:0] amt_d  [CNT_W];
   op_e              op_q   [CNT_W];
   op_e              op_d   [CNT_W];

   // Stage inputs: stage 0 from the ports, stage k from stage k-1
   logic             src_v    [CNT_W];
   logic [WIDTH-1:0] src_data [CNT_W];
   logic [CNT_W-1:0] src_amt  [CNT_W];
   op_e              src_op   [CNT_W];

   logic             adv;
   logic [CNT_W-1:0] v_all;

   // Shift one operand by a fixed distance sh (0 < sh < WIDTH).
   // Rotations take a window out of the operand doubled side by side.
   function automatic logic [WIDTH-1:0] stage_shift(
      input logic [WIDTH-1:0] d,
      input op_e              op,
      input int unsigned      sh
   );
      logic [2*WIDTH-1:0] dd;
      logic [2*WIDTH-1:0] t;
      dd = {d, d};
      unique case (op)
         OP_ROL:  t = dd >> (WIDTH - sh);
         OP_SLL:  t = {{WIDTH{1'b0}}, d} << sh;
         OP_ROR:  t = dd >> sh;
         default: t = {{WIDTH{1'b0}}, d} >> sh;
      endcase
      return t[WIDTH-1:0];
   endfunction

   // Global advance: the pipeline moves whenever the output slot is empty or being taken
   always_comb begin
      adv      = ~out_valid | out_ready;
      in_ready = adv;
   end

   // Route each stage's input from the previous stage (or the request ports)
   always_comb begin
      src_v[0]    = in_valid;
      src_data[0] = in_data;
      src_amt[0]  = in_amt;
      src_op[0]   = op_e'(in_op);
      for (int unsigned k = 1; k < CNT_W; k++) begin
         src_v[k]    = v_q[k-1];
         src_data[k] = data_q[k-1];
         src_amt[k]  = amt_q[k-1];
         src_op[k]   = op_q[k-1];
      end
   end

   for (genvar k = 0; k < CNT_W; k++) begin : g_stage
      localparam int unsigned SH = 32'd1 << k;

      // Next state for stage k: load shifted input on advance, hold on stall, flush clears valid
      always_comb begin
         v_d[k]    = v_q[k];
         data_d[k] = data_q[k];
         amt_d[k]  = amt_q[k];
         op_d[k]   = op_q[k];
         if (adv) begin
            v_d[k]    = src_v[k];
            data_d[k] = src_amt[k][k] ? stage_shift(src_data[k], src_op[k], SH) : src_data[k];
            amt_d[k]  = src_amt[k];
            op_d[k]   = src_op[k];
         end
         if (flush) begin
            v_d[k] = 1'b0;
         end
      end

      // Stage k register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q[k]    <= 1'b0;
            data_q[k] <= '0;
            amt_q[k]  <= '0;
            op_q[k]   <= OP_ROL;
         end else begin
            v_q[k]    <= v_d[k];
            data_q[k] <= data_d[k];
            amt_q[k]  <= amt_d[k];
            op_q[k]   <= op_d[k];
         end
      end

      assign v_all[k] = v_q[k];
   end

   // Result comes straight from the last stage; busy if any stage holds an entry
   always_comb begin
      out_valid = v_q[CNT_W-1];
      out_data  = data_q[CNT_W-1];
      busy      = |v_all;
   end

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed and randomized checks of shift_pipe against a queue-based model.
module tb_shift_pipe;

   localparam int W   = 16;
   localparam int CW  = 4;
   localparam int W2  = 32;
   localparam int CW2 = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [W-1:0]  in_data, out_data;
   logic [CW-1:0] in_amt;
   logic [1:0]    in_op;

   logic           flush32, in_valid32, in_ready32, out_valid32, out_ready32, busy32;
   logic [W2-1:0]  in_data32, out_data32;
   logic [CW2-1:0] in_amt32;
   logic [1:0]     in_op32;

   shift_pipe #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_amt(in_amt), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   shift_pipe #(.WIDTH(W2)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush32),
      .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
      .in_amt(in_amt32), .in_op(in_op32),
      .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
      .busy(busy32)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference shift from the arithmetic definition of each op on a w-bit value
   function automatic logic [63:0] ref_shift(input logic [63:0] d, input int w, input int n,
                                             input logic [1:0] op);
      logic [63:0] mask;
      logic [63:0] x;
      mask = (64'd1 << w) - 64'd1;
      x    = d & mask;
      case (op)
         2'b00:   return ((x << n) | (x >> (w - n))) & mask;
         2'b01:   return (x << n) & mask;
         2'b10:   return ((x >> n) | (x << (w - n))) & mask;
         default: return x >> n;
      endcase
   endfunction

   // Model: entries in flight with the number of advancing edges they have seen
   typedef struct {
      logic [W-1:0] res;
      int           age;
   } ent_t;

   ent_t         q[$];
   bit           exp_ov;
   bit           m_adv;
   logic [63:0]  tmp64;
   logic [W-1:0] tmp16;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         exp_ov = (q.size() > 0) && (q[0].age == CW);
         check("out_valid", out_valid, exp_ov);
         if (exp_ov) check("out_data", out_data, q[0].res);
         check("busy", busy, q.size() != 0);
         check("in_ready", in_ready, !exp_ov || out_ready);
         m_adv = !exp_ov || out_ready;
         if (exp_ov && out_ready) void'(q.pop_front());
         if (flush) begin
            q.delete();
         end else if (m_adv) begin
            foreach (q[i]) q[i].age++;
            if (in_valid) begin
               tmp64 = ref_shift(64'(in_data), W, int'(in_amt), in_op);
               tmp16 = tmp64[W-1:0];
               q.push_back('{res: tmp16, age: 1});
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [W-1:0] d, input int a, input int op);
      in_valid = v;
      in_data  = d;
      in_amt   = a[CW-1:0];
      in_op    = op[1:0];
   endtask

   logic [W-1:0]  t2_exp [4];
   int            lat;
   logic [W2-1:0] save32;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      t2_exp = '{16'h4218, 16'h4210, 16'h1842, 16'h0842};
      rst_n = 1'b0;
      flush = 1'b0; out_ready = 1'b1;
      drive(0, '0, 0, 0);
      flush32 = 1'b0; in_valid32 = 1'b0; in_data32 = '0; in_amt32 = '0; in_op32 = '0;
      out_ready32 = 1'b1;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);

      // Four ops on 16'h8421 by 4, one at a time
      for (int op = 0; op < 4; op++) begin
         drive(1, 16'h8421, 4, op);
         cyc();
         drive(0, '0, 0, 0);
         lat = 1;
         while (!out_valid && lat < 20) begin
            cyc();
            lat++;
         end
         check("ops_latency", lat, CW);
         check("ops_result", out_data, t2_exp[op]);
         cyc();
      end

      // Back-to-back SRL of 16'hFFFF by 0..15
      for (int n = 0; n < 16; n++) begin
         drive(1, 16'hFFFF, n, 3);
         cyc();
      end
      drive(0, '0, 0, 0);
      repeat (8) cyc();

      // Backpressure with full pipeline
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, W'($urandom), int'($urandom_range(0, W-1)), int'($urandom_range(0, 3)));
         cyc();
      end
      drive(1, 16'hBEEF, 3, 2);
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready", in_ready, 0);
         cyc();
      end
      drive(0, '0, 0, 0);
      out_ready = 1'b1;
      repeat (6) cyc();

      // Flush with two in flight and a request in the flush cycle
      drive(1, 16'h1234, 1, 0);
      cyc();
      drive(1, 16'h5678, 2, 1);
      cyc();
      drive(1, 16'h9ABC, 3, 2);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      check("flush_busy", busy, 0);
      drive(1, 16'h00F0, 4, 3);
      cyc();
      drive(0, '0, 0, 0);
      lat = 1;
      while (!out_valid && lat < 20) begin
         cyc();
         lat++;
      end
      check("post_flush_latency", lat, CW);
      check("post_flush_result", out_data, 16'h000F);
      repeat (3) cyc();

      // Asynchronous reset with three ops in flight
      for (int i = 0; i < 3; i++) begin
         drive(1, W'($urandom), int'($urandom_range(0, W-1)), int'($urandom_range(0, 3)));
         cyc();
      end
      drive(0, '0, 0, 0);
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_busy", busy, 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("after_rst_quiet", out_valid, 0);
         cyc();
      end

      // Randomized traffic with stalls and occasional flushes
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, W'($urandom), int'($urandom_range(0, W-1)),
               int'($urandom_range(0, 3)));
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 49) == 0);
         cyc();
      end
      drive(0, '0, 0, 0);
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (10) cyc();
      check("drained_busy", busy, 0);

      // 32-bit instance: ROR 1 by 31, then ROL by 0
      in_valid32 = 1'b1; in_data32 = 32'h0000_0001; in_amt32 = 5'd31; in_op32 = 2'b10;
      cyc();
      in_valid32 = 1'b0;
      lat = 1;
      while (!out_valid32 && lat < 20) begin
         cyc();
         lat++;
      end
      check("w32_ror_latency", lat, CW2);
      check("w32_ror_result", out_data32, 32'h0000_0002);
      check("w32_ror_model", out_data32, ref_shift(64'h1, W2, 31, 2'b10));
      cyc();
      save32 = $urandom;
      in_valid32 = 1'b1; in_data32 = save32; in_amt32 = '0; in_op32 = 2'b00;
      cyc();
      in_valid32 = 1'b0;
      lat = 1;
      while (!out_valid32 && lat < 20) begin
         cyc();
         lat++;
      end
      check("w32_rol0_latency", lat, CW2);
      check("w32_rol0_result", out_data32, save32);
      repeat (3) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
